// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (Moore). Sequences fetch/decode/execute over a
// shared ALU and unified memory for R-type, lw, sw, beq, addi and j.
// Optional feature macro: MIPS_CTRL_BNE_EN adds bne (Op=000101) via BRANCH.
//
// state   | meaning
// FETCH   | read instruction, PC <= PC+4
// DECODE  | branch target into ALUOut, dispatch on Op
// MEMADR  | effective address A+SignImm
// MEMRD   | read data memory at ALUOut
// MEMWB   | write loaded data to rt
// MEMWR   | write B to memory at ALUOut
// EXECUTE | R-type ALU op on A,B
// ALUWB   | write ALUOut to rd
// BRANCH  | compare A,B; PC <= ALUOut if taken
// ADDIEX  | A+SignImm
// ADDIWB  | write ALUOut to rt
// JUMP    | PC <= jump target
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCEn,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         PCSrc,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;
  logic   pc_write, branch, mem_write_c, ir_write_c, reg_write_c, branch_cond;

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

`ifdef MIPS_CTRL_BNE_EN
  logic branch_ne_q;

  // Remember in DECODE whether the branch sense is inverted (bne).
  always_ff @(posedge clk) begin
    if (reset)                 branch_ne_q <= 1'b0;
    else if (state_q == DECODE) branch_ne_q <= (Op == OP_BNE);
  end

  assign branch_cond = Zero ^ branch_ne_q;
`else
  assign branch_cond = Zero;
`endif

  // Next-state selection and per-state control decode.
  always_comb begin
    state_d     = FETCH;
    IorD        = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    reg_write_c = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = 3'b010;
    PCSrc       = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write_c = 1'b1;
        pc_write   = 1'b1;
        ALUSrcB    = 2'b01;
        state_d    = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        MemToReg    = 1'b1;
        reg_write_c = 1'b1;
      end
      MEMWR: begin
        IorD        = 1'b1;
        mem_write_c = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
        state_d = ALUWB;
      end
      ALUWB: begin
        RegDst      = 1'b1;
        reg_write_c = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: reg_write_c = 1'b1;
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Architectural write strobes are suppressed while reset is held.
  assign MemWrite = mem_write_c & ~reset;
  assign IRWrite  = ir_write_c & ~reset;
  assign RegWrite = reg_write_c & ~reset;
  assign PCEn     = (pc_write | (branch & branch_cond)) & ~reset;
  assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl against a
// per-instruction path model and a per-state control table.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0, Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, PCEn, RegDst, MemToReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int   n_pass = 0, n_total = 0;
  logic model_bne = 1'b0;

  typedef int iq_t[$];

`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .state(state)
  );

  always #5 clk = ~clk;

  // Sequence of states an instruction visits, FETCH through last state.
  function automatic iq_t path(input logic [5:0] op);
    iq_t q;
    case (op)
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000000: q = '{0, 1, 6, 7};
      6'b000100: q = '{0, 1, 8};
      6'b001000: q = '{0, 1, 9, 10};
      6'b000010: q = '{0, 1, 11};
      6'b000101: q = BNE_EN ? '{0, 1, 8} : '{0, 1};
      default:   q = '{0, 1};
    endcase
    return q;
  endfunction

  // Expected control word for a state:
  // {IorD,MemWrite,IRWrite,PCEn,RegDst,MemToReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc}
  function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] funct,
                                           input logic zero, input logic bne, input logic rst);
    logic iord = 0, mw = 0, irw = 0, pcw = 0, br = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pcen;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] ac = 3'b010;
    case (st)
      0:  begin irw = 1; pcw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin
            sa = 1;
            case (funct)
              6'b100010: ac = 3'b110;
              6'b100100: ac = 3'b000;
              6'b100101: ac = 3'b001;
              6'b101010: ac = 3'b111;
              default:   ac = 3'b010;
            endcase
          end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ac = 3'b110; ps = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    pcen = pcw | (br & (zero ^ bne));
    if (rst) begin mw = 0; rw = 0; irw = 0; pcen = 0; end
    return {iord, mw, irw, pcen, rd, m2r, rw, sa, sb, ac, ps};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int st);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s st=%0d observed=%h expected=%h", tag, st, obs, exp);
  endtask

  // One cycle: drive inputs after negedge, check outputs, let posedge advance.
  task automatic step(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                      input int exp_st, input logic rst);
    logic [14:0] obs;
    @(negedge clk);
    reset = rst;
    Op    = (exp_st == 1 || exp_st == 2) ? op : 6'($urandom);
    Funct = (exp_st == 6) ? funct : 6'($urandom);
    Zero  = (exp_st == 8) ? zero : 1'($urandom);
    #1;
    obs = {IorD, MemWrite, IRWrite, PCEn, RegDst, MemToReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc};
    chk("state", 32'(state), 32'(exp_st), exp_st);
    chk("ctrl", 32'(obs), 32'(exp_ctrl(exp_st, Funct, Zero, model_bne, rst)), exp_st);
    if (rst) model_bne = 1'b0;
    else if (exp_st == 1) model_bne = BNE_EN && (op == 6'b000101);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input int zmode);
    iq_t q = path(op);
    foreach (q[i]) step(op, funct, (zmode == 2) ? 1'($urandom) : 1'(zmode), q[i], 1'b0);
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3f, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};

    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    step(6'h00, 6'h00, 1'b0, 0, 1'b1);

    run_instr(6'h23, 6'h00, 0);        // lw
    run_instr(6'h00, 6'h2a, 0);        // slt
    run_instr(6'h04, 6'h00, 1);        // beq taken
    run_instr(6'h04, 6'h00, 0);        // beq not taken
    run_instr(6'h2b, 6'h00, 0);        // sw
    run_instr(6'h02, 6'h00, 0);        // j
    run_instr(6'h3f, 6'h00, 0);        // illegal
    run_instr(6'h05, 6'h00, 0);        // bne, Zero=0
    run_instr(6'h05, 6'h00, 1);        // bne, Zero=1
    run_instr(6'h00, 6'h22, 0);        // sub
    run_instr(6'h08, 6'h00, 0);        // addi

    // Reset held three cycles while a lw sits in MEMRD.
    step(6'h23, 6'h00, 1'b0, 0, 1'b0);
    step(6'h23, 6'h00, 1'b0, 1, 1'b0);
    step(6'h23, 6'h00, 1'b0, 2, 1'b0);
    step(6'h23, 6'h00, 1'b0, 3, 1'b1);
    step(6'h23, 6'h00, 1'b0, 0, 1'b1);
    step(6'h23, 6'h00, 1'b0, 0, 1'b1);
    run_instr(6'h23, 6'h00, 0);

    for (int n = 0; n < 150; n++) begin
      op = (($urandom % 10) == 0) ? 6'($urandom) : ops[$urandom % 9];
      fn = (($urandom % 4) == 0) ? 6'($urandom) : fns[$urandom % 6];
      run_instr(op, fn, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: unified memory, instruction register, and a shared ALU that also computes PC+4 and the branch target.
- Replaces the single-cycle control unit in the multicycle core variant.
- Decodes Op/Funct from the instruction register. Issues per-state mux selects, write enables and ALU control.
- Supports R-type (add/sub/and/or/slt), lw, sw, beq, addi, j.

Parameters:
- STATE_W, 4, width of state register and debug state port

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; forces FETCH on next edge
- Op  input  6  opcode, IR[31:26]; valid from DECODE onward
- Funct  input  6  function field, IR[5:0]
- Zero  input  1  ALU zero flag, combinational from datapath
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register load enable
- PCEn  output  1  PC load enable: PCWrite | (Branch & Zero)
- RegDst  output  1  register write address: 0=rt, 1=rd
- MemToReg  output  1  register write data: 0=ALUOut, 1=Data
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A: 0=PC, 1=A reg
- ALUSrcB  output  2  ALU B: 00=B reg, 01=4, 10=SignImm, 11=SignImm<<2
- ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- state  output  STATE_W  current state, debug/verification only

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, next state is FETCH.
- Outputs decode from the state register only. The exceptions are PCEn, which also depends on Zero, and ALUControl in EXECUTE, which depends on Funct.
- Unlisted outputs default to 0; ALUControl defaults to 010.
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, PCSrc=00. Next state is DECODE.
- DECODE: ALUSrcB=11, which computes the branch target into ALUOut. Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH (executes as a NOP; PC already advanced)
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state is MEMRD if Op=100011, else MEMWR.
- MEMRD: IorD=1. Next state is MEMWB.
- MEMWB: MemToReg=1, RegWrite=1. Next state is FETCH.
- MEMWR: IorD=1, MemWrite=1. Next state is FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl by Funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other Funct->010. Next state is ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1. Next state is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state is ADDIWB.
- ADDIWB: RegWrite=1. Next state is FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state is FETCH.
- Instruction latency, FETCH to next FETCH inclusive: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Reset:
  - While reset=1, MemWrite, RegWrite, IRWrite and PCEn are forced to 0 combinationally.
  - state=FETCH after the first edge with reset=1.
  - Reset mid-instruction abandons it with no partial architectural writes after the reset edge.
  - First FETCH with IRWrite=1 occurs in the first cycle after reset deasserts.
- Op/Funct changes outside DECODE/MEMADR/EXECUTE are ignored. Zero matters only in BRANCH.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN
- Defined:
  - Op=000101 (bne) goes DECODE->BRANCH.
  - A BranchNe flag is registered in DECODE (1 for bne, 0 otherwise).
  - In BRANCH, PCEn = PCWrite | (Branch & (Zero ^ BranchNe)).
- Undefined: 000101 is illegal (DECODE->FETCH) and PCEn = PCWrite | (Branch & Zero).

Test Plan:
- Hold reset 3 cycles mid-lw (state=MEMRD), then release -> state=0; MemWrite/RegWrite/PCEn/IRWrite=0 throughout reset; next cycle IRWrite=1, PCEn=1.
- lw (Op=100011) -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4; IorD=1 in state 3.
- R-type slt (Op=0, Funct=101010) -> 0,1,6,7,0; ALUControl=111 in state 6; RegDst=1, RegWrite=1 in state 7.
- beq, Zero=1 then Zero=0 -> 0,1,8,0; PCEn=1 in state 8 only when Zero=1; ALUControl=110, PCSrc=01.
- sw, then j, then Op=111111 -> sw: 0,1,2,5,0 with MemWrite=1 only in 5; j: 0,1,11,0 with PCSrc=10, PCEn=1; illegal: 0,1,0 with no RegWrite/MemWrite.
- With MIPS_CTRL_BNE_EN, Op=000101, Zero=0 -> state 8, PCEn=1; Zero=1 -> PCEn=0. Without the macro -> 0,1,0.
